// File: rtl/uart_rx_os_if.sv
// Output stream bundle of the oversampling UART receiver.
// master drives head word and flags, slave returns m_ready.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_BITS-1:0] m_data;
    logic                 m_err_frame;
    logic                 m_err_parity;
    logic                 m_break;

    modport master (
        output m_valid, m_data, m_err_frame, m_err_parity, m_break,
        input  m_ready
    );
    modport slave (
        input  m_valid, m_data, m_err_frame, m_err_parity, m_break,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver with 3-sample majority vote,
// runtime baud divisor, error tagging and an output FIFO.
// Ports: clk, rst_n, baud_div, rx, m (stream master),
// overrun/clr_overrun, fifo_level, busy.
module uart_rx_os #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BIT    = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_W       = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          rx,
    uart_rx_os_if.master                  m,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int W   = DATA_BITS + 3;

    localparam logic [OSW-1:0] OS_S0  = OSW'(OVERSAMPLE/2 - 1);
    localparam logic [OSW-1:0] OS_S1  = OSW'(OVERSAMPLE/2);
    localparam logic [OSW-1:0] OS_MID = OSW'(OVERSAMPLE/2 + 1);
    localparam logic [OSW-1:0] OS_END = OSW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ARM, IDLE, START, DATA, PARITY, STOP
    } state_t;

    state_t               r_state;
    logic                 r_rx_meta, r_rx_s;
    logic [DIV_W-1:0]     r_div, r_cnt;
    logic [OSW-1:0]       r_os;
    logic [BW-1:0]        r_bit;
    logic [1:0]           r_smp;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_par, r_ferr;
    logic                 r_commit;
    logic [W-1:0]         r_cword;

    logic [DIV_W-1:0]     w_baud, w_div;
    logic                 w_tick, w_start, w_maj, w_ferr, w_perr, w_brk;

    // Two-flop synchroniser; idle-high reset avoids a fake start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Live divisor while waiting, frozen copy during a frame.
    assign w_baud  = (baud_div == '0) ? DIV_W'(1) : baud_div;
    assign w_div   = (r_state == ARM || r_state == IDLE) ? w_baud : r_div;
    assign w_tick  = (r_cnt >= w_div - DIV_W'(1));
    assign w_start = (r_state == IDLE) && !r_rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_cnt <= '0;
        else if (w_start) r_cnt <= '0;
        else if (w_tick)  r_cnt <= '0;
        else              r_cnt <= r_cnt + DIV_W'(1);
    end

    assign w_maj = (r_smp[0] & r_smp[1]) | (r_rx_s & (r_smp[0] | r_smp[1]));
    assign w_ferr = r_ferr | !w_maj;
    assign w_perr = (PARITY_TYPE == 0) ? 1'b0 :
                    (PARITY_TYPE == 1) ? (^r_data ^ r_par) :
                                         ~(^r_data ^ r_par);
    assign w_brk  = w_ferr && (r_data == '0) &&
                    ((PARITY_TYPE == 0) || !r_par);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARM;
            r_div    <= DIV_W'(1);
            r_os     <= '0;
            r_bit    <= '0;
            r_smp    <= 2'b11;
            r_data   <= '0;
            r_par    <= 1'b0;
            r_ferr   <= 1'b0;
            r_commit <= 1'b0;
            r_cword  <= '0;
        end else begin
            r_commit <= 1'b0;
            if (r_state == ARM) begin
                if (!r_rx_s) begin
                    r_os <= '0;
                end else if (w_tick) begin
                    if (r_os == OS_END) begin
                        r_os    <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_os <= r_os + OSW'(1);
                    end
                end
            end else if (r_state == IDLE) begin
                if (!r_rx_s) begin
                    r_state <= START;
                    r_div   <= w_baud;
                    r_os    <= '0;
                    r_bit   <= '0;
                    r_ferr  <= 1'b0;
                    r_par   <= 1'b0;
                end
            end else if (w_tick) begin
                r_os <= (r_os == OS_END) ? '0 : r_os + OSW'(1);
                if (r_os == OS_S0 || r_os == OS_S1)
                    r_smp <= {r_smp[0], r_rx_s};
                unique case (r_state)
                    START: begin
                        if (r_os == OS_MID && w_maj) begin
                            r_state <= IDLE;
                        end else if (r_os == OS_END) begin
                            r_state <= DATA;
                            r_bit   <= '0;
                        end
                    end
                    DATA: begin
                        if (r_os == OS_MID)
                            r_data <= {w_maj, r_data[DATA_BITS-1:1]};
                        if (r_os == OS_END) begin
                            if (r_bit == BW'(DATA_BITS - 1)) begin
                                r_bit   <= '0;
                                r_state <= (PARITY_TYPE != 0) ? PARITY : STOP;
                            end else begin
                                r_bit <= r_bit + BW'(1);
                            end
                        end
                    end
                    PARITY: begin
                        if (r_os == OS_MID)
                            r_par <= w_maj;
                        if (r_os == OS_END) begin
                            r_bit   <= '0;
                            r_state <= STOP;
                        end
                    end
                    STOP: begin
                        if (r_os == OS_MID) begin
                            r_ferr <= w_ferr;
                            // Commit at the last stop mid-point so the
                            // next start edge is not missed.
                            if (r_bit == BW'(STOP_BIT - 1)) begin
                                r_commit <= 1'b1;
                                r_cword  <= {w_brk, w_perr, w_ferr, r_data};
                                r_state  <= IDLE;
                            end
                        end
                        if (r_os == OS_END)
                            r_bit <= r_bit + BW'(1);
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (r_state != ARM) && (r_state != IDLE);

    logic [W-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_lvl;
    logic          w_pop, w_full, w_push, w_drop;
    logic [W-1:0]  w_head;

    assign w_pop  = m.m_valid && m.m_ready;
    assign w_full = (r_lvl == (AW+1)'(FIFO_DEPTH));
    assign w_push = r_commit && (!w_full || w_pop);
    assign w_drop = r_commit && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_lvl <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= r_cword;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            if (w_push && !w_pop)
                r_lvl <= r_lvl + (AW+1)'(1);
            else if (w_pop && !w_push)
                r_lvl <= r_lvl - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           overrun <= 1'b0;
        else if (w_drop)      overrun <= 1'b1;
        else if (clr_overrun) overrun <= 1'b0;
    end

    assign w_head         = (r_lvl != '0) ? r_mem[r_rp] : '0;
    assign m.m_valid      = (r_lvl != '0);
    assign m.m_data       = w_head[DATA_BITS-1:0];
    assign m.m_err_frame  = w_head[DATA_BITS];
    assign m.m_err_parity = w_head[DATA_BITS+1];
    assign m.m_break      = w_head[DATA_BITS+2];
    assign fifo_level     = r_lvl;
endmodule
